// File: rtl/okd_pkg.sv
// okd_pkg: shared types and constants for the sequential restoring divider.
package okd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam int OKD_WIDTH = 64;

    localparam logic [OKD_WIDTH-1:0] DIV0_QUOTIENT = '1;

    function automatic int okd_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/okd_div_step.sv
// okd_div_step: one combinational restoring-division step (shift in a dividend bit, trial subtract).
module okd_div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH:0]   pr,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_pr,
    output logic             q_bit
);

    logic [WIDTH+1:0] pr_shift;
    logic [WIDTH+1:0] diff;

    // pr stays below the divisor, so its top bit is zero and the extra headroom bit only carries the borrow
    assign pr_shift = {pr, dividend_msb};
    assign diff     = pr_shift - {2'b00, divisor};
    assign q_bit    = ~diff[WIDTH+1];
    assign next_pr  = q_bit ? diff[WIDTH:0] : pr_shift[WIDTH:0];

endmodule

// File: rtl/okd_seq_divider_64bit.sv
// okd_seq_divider_64bit: multi-cycle radix-2 restoring unsigned divider with start/busy/done handshake.
module okd_seq_divider_64bit
    import okd_pkg::*;
#(
    parameter int WIDTH = OKD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CNT_W = okd_cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   pr_q, pr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   next_pr;
    logic             q_bit;

    okd_div_step #(.WIDTH(WIDTH)) u_step (
        .pr           (pr_q),
        .dividend_msb (dvd_q[WIDTH-1]),
        .divisor      (dvs_q),
        .next_pr      (next_pr),
        .q_bit        (q_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        if (state_q == RUN) begin
            // quotient bits fill the dividend register from the bottom as its bits are consumed
            dvd_d = {dvd_q[WIDTH-2:0], q_bit};
            pr_d  = next_pr;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d = FIN;
                q_d     = {dvd_q[WIDTH-2:0], q_bit};
                r_d     = next_pr[WIDTH-1:0];
                dz_d    = 1'b0;
            end
        end else if (start) begin
            dvd_d   = a;
            dvs_d   = b;
            pr_d    = '0;
            cnt_d   = '0;
            state_d = (b != '0) ? RUN : FIN;
            if (b == '0) begin
                q_d  = {WIDTH{DIV0_QUOTIENT[0]}};
                r_d  = a;
                dz_d = 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == FIN);
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_okd_seq_divider_64bit.sv
// tb_okd_seq_divider_64bit: directed vector table plus handshake corner sequences for the divider.
module tb_okd_seq_divider_64bit;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        logic        dz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [63:0] q, r;

    int total = 0;
    int bad = 0;

    vec_t vt[10];

    okd_seq_divider_64bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%016h exp=0x%016h", nm, got, exp);
        end
    endtask

    // start one division and wait for done; lat counts edges after the accepting edge
    task automatic do_div(input logic [63:0] av, input logic [63:0] bv,
                          output int lat, output logic bs, output logic ov);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bs = busy;
        ov = busy & done;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            bs |= busy;
            ov |= busy & done;
        end
    endtask

    initial begin
        int   lat;
        logic bs, ov, saw_done;

        vt[0] = '{64'd100, 64'd7, 64'd14, 64'd2, 1'b0};
        vt[1] = '{64'hF618F618F618F618, 64'hEE48EE48EE48EE48, 64'd1, 64'h07D007D007D007D0, 1'b0};
        vt[2] = '{64'hFFFFFFFFFFFFFFFF, 64'd1, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b0};
        vt[3] = '{64'd5, 64'd9, 64'd0, 64'd5, 1'b0};
        vt[4] = '{64'h1234, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'h1234, 1'b1};
        vt[5] = '{64'd100, 64'd7, 64'd14, 64'd2, 1'b0};
        vt[6] = '{64'd0, 64'd5, 64'd0, 64'd0, 1'b0};
        vt[7] = '{64'd7, 64'd7, 64'd1, 64'd0, 1'b0};
        vt[8] = '{64'h8000000000000000, 64'd3, 64'h2AAAAAAAAAAAAAAA, 64'd2, 1'b0};
        vt[9] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_q", q, 64'd0);
        chk("rst_r", r, 64'd0);
        chk("rst_dz", {63'd0, div_by_zero}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            do_div(vt[i].a, vt[i].b, lat, bs, ov);
            chk($sformatf("v%0d_lat", i), 64'(lat), (vt[i].b != 0) ? 64'd64 : 64'd0);
            chk($sformatf("v%0d_q", i), q, vt[i].q);
            chk($sformatf("v%0d_r", i), r, vt[i].r);
            chk($sformatf("v%0d_dz", i), {63'd0, div_by_zero}, {63'd0, vt[i].dz});
            chk($sformatf("v%0d_busy_seen", i), {63'd0, bs}, {63'd0, vt[i].b != 0});
            chk($sformatf("v%0d_overlap", i), {63'd0, ov}, 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
            chk($sformatf("v%0d_hold_q", i), q, vt[i].q);
        end

        // start held high across a run with operands changing mid-run, then back-to-back restart
        @(negedge clk);
        a = 64'd100;
        b = 64'd7;
        start = 1'b1;
        @(negedge clk);
        a = 64'd1000;
        b = 64'd3;
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_lat", 64'(lat), 64'd64);
        chk("hold_q", q, 64'd14);
        chk("hold_r", r, 64'd2);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_lat", 64'(lat), 64'd64);
        chk("b2b_q", q, 64'd333);
        chk("b2b_r", r, 64'd1);

        // reset partway through a run aborts it with no completion
        @(negedge clk);
        a = 64'd100;
        b = 64'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_q", q, 64'd0);
        chk("abort_r", r, 64'd0);
        saw_done = 1'b0;
        repeat (70) begin
            @(negedge clk);
            saw_done |= done;
        end
        chk("abort_no_done", {63'd0, saw_done}, 64'd0);
        do_div(64'd100, 64'd7, lat, bs, ov);
        chk("after_rst_lat", 64'(lat), 64'd64);
        chk("after_rst_q", q, 64'd14);
        chk("after_rst_r", r, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
